// File: rtl/freq_meas_seq.sv
// freq_meas_seq: gate/latch/clear sequencer for the frequency meter with start/busy/done handshake.
// Optional FMS_AUTO_REPEAT_EN adds a repeat_en input that chains DONE straight back into GATE.
module freq_meas_seq #(
   parameter int GATE_CYC   = 8,
   parameter int SETTLE_CYC = 1,
   parameter int HOLD_CYC   = 3,
   parameter int CNT_W      = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       cnt_ovf,
`ifdef FMS_AUTO_REPEAT_EN
   input  logic       repeat_en,
`endif
   output logic       enb,
   output logic       lock,
   output logic       clr,
   output logic       busy,
   output logic       done,
   output logic       ovf_err,
   output logic [2:0] phase
);
   typedef enum logic [2:0] {IDLE, GATE, SETTLE, LATCH, HOLD, CLEAR, DONE} state_t;
   localparam logic [CNT_W:0] G_LAST = (CNT_W+1)'(GATE_CYC - 1);
   localparam logic [CNT_W:0] S_LAST = (CNT_W+1)'(SETTLE_CYC - 1);
   localparam logic [CNT_W:0] H_LAST = (CNT_W+1)'(HOLD_CYC > 0 ? HOLD_CYC - 1 : 0);
   state_t state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic aborted, ovf_seen, last, rep;
`ifdef FMS_AUTO_REPEAT_EN
   assign rep = repeat_en;
`else
   assign rep = 1'b0;
`endif
   // exit compare on len-1 in CNT_W+1 bits so a full 2**CNT_W length never wraps
   assign last = {1'b0, cnt} == (state == GATE ? G_LAST : state == SETTLE ? S_LAST : H_LAST);
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = start && !abort ? GATE : IDLE;
         GATE:    state_nx = abort ? CLEAR : last ? SETTLE : GATE;
         SETTLE:  state_nx = abort ? CLEAR : last ? LATCH : SETTLE;
         LATCH:   state_nx = abort || HOLD_CYC == 0 ? CLEAR : HOLD;
         HOLD:    state_nx = abort || last ? CLEAR : HOLD;
         CLEAR:   state_nx = aborted ? IDLE : DONE;
         DONE:    state_nx = rep && !abort ? GATE : IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         aborted  <= 1'b0;
         ovf_seen <= 1'b0;
         ovf_err  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= state_nx == state && state inside {GATE, SETTLE, HOLD} ? cnt + 1'b1 : '0;
         if (state_nx == GATE && state != GATE) begin
            aborted  <= 1'b0;
            ovf_seen <= 1'b0;
         end else begin
            if (abort && state inside {GATE, SETTLE, LATCH, HOLD}) aborted <= 1'b1;
            if (cnt_ovf && state inside {GATE, SETTLE}) ovf_seen <= 1'b1;
         end
         if (state_nx == DONE && state != DONE) ovf_err <= ovf_seen;
      end
   end
   assign enb   = state == GATE;
   assign lock  = state == LATCH;
   assign clr   = state == CLEAR;
   assign busy  = state inside {GATE, SETTLE, LATCH, HOLD, CLEAR};
   assign done  = state == DONE;
   assign phase = state;
endmodule

// File: tb/tb_freq_meas_seq.sv
// tb_freq_meas_seq: random and directed checks of two sequencer builds against an offset-based model.
module tb_freq_meas_seq;
   logic clk = 1'b0, rst_n, start, abort, cnt_ovf, rpt;
   logic [8:0] o0, o1;
   int cmp_n = 0, fail_n = 0;
   int gl[2] = '{8, 1};
   int sl[2] = '{1, 1};
   int hl[2] = '{3, 0};
   int mode[2], k[2];
   bit ovs[2], oe[2];
   int ph_log[16];
   int lit0[16] = '{1,1,1,1,1,1,1,1,2,3,4,4,4,5,6,0};
   int lit1[6]  = '{1,2,3,5,6,0};
   always #5 clk = ~clk;
   freq_meas_seq dut0 (.clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cnt_ovf(cnt_ovf),
`ifdef FMS_AUTO_REPEAT_EN
      .repeat_en(rpt),
`endif
      .enb(o0[0]), .lock(o0[1]), .clr(o0[2]), .busy(o0[3]), .done(o0[4]), .ovf_err(o0[5]), .phase(o0[8:6]));
   freq_meas_seq #(.GATE_CYC(1), .SETTLE_CYC(1), .HOLD_CYC(0)) dut1 (.clk(clk), .rst_n(rst_n), .start(start),
      .abort(abort), .cnt_ovf(cnt_ovf),
`ifdef FMS_AUTO_REPEAT_EN
      .repeat_en(rpt),
`endif
      .enb(o1[0]), .lock(o1[1]), .clr(o1[2]), .busy(o1[3]), .done(o1[4]), .ovf_err(o1[5]), .phase(o1[8:6]));
   // phase as a function of cycles since GATE entry, from cumulative segment lengths
   function automatic int seg(int i, int kk);
      int g = gl[i], s = g + sl[i], h = s + 1 + hl[i];
      return kk < g ? 1 : kk < s ? 2 : kk == s ? 3 : kk < h ? 4 : kk == h ? 5 : 6;
   endfunction
   function automatic int ph(int i);
      return mode[i] == 0 ? 0 : mode[i] == 2 ? 5 : seg(i, k[i]);
   endfunction
   function automatic logic [8:0] exp_vec(int i);
      int p = ph(i);
      return {3'(p), oe[i], p == 6, p >= 1 && p <= 5, p == 5, p == 3, p == 1};
   endfunction
   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin mode[i] = 0; k[i] = 0; ovs[i] = 0; oe[i] = 0; end
   endtask
   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         int p = ph(i);
         if ((p == 1 || p == 2) && cnt_ovf) ovs[i] = 1;
         if (mode[i] == 2) mode[i] = 0;
         else if (p == 0) begin
            if (start && !abort) begin mode[i] = 1; k[i] = 0; ovs[i] = 0; end
         end else if (p <= 4 && abort) mode[i] = 2;
         else if (p == 6) begin
            if (rpt && !abort) begin k[i] = 0; ovs[i] = 0; end else mode[i] = 0;
         end else begin
            k[i]++;
            if (ph(i) == 6) oe[i] = ovs[i];
         end
      end
   endtask
   task automatic chk(input string nm, input int act, input int exp);
      cmp_n++;
      if (act != exp) begin
         fail_n++;
         $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, act, exp);
      end
   endtask
   task automatic check_all();
      chk("model_cmp_inst0", int'(o0), int'(exp_vec(0)));
      chk("model_cmp_inst1", int'(o1), int'(exp_vec(1)));
   endtask
   task automatic cyc(input bit s, input bit a, input bit ov);
      start = s; abort = a; cnt_ovf = ov;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask
   task automatic run(input int n);
      repeat (n) cyc(0, 0, 0);
   endtask
   initial begin
      int r1, r2, pe, dn;
      rst_n = 0; start = 0; abort = 0; cnt_ovf = 0; rpt = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      chk("reset_outputs", int'(o0), 0);
      rst_n = 1;
      // nominal sequence, phase trace pinned by literals
      cyc(1, 0, 0);
      ph_log[0] = int'(o0[8:6]);
      chk("inst1_phase0", int'(o1[8:6]), lit1[0]);
      for (int j = 1; j < 16; j++) begin
         cyc(0, 0, 0);
         ph_log[j] = int'(o0[8:6]);
         if (j < 6) chk("inst1_phase", int'(o1[8:6]), lit1[j]);
      end
      for (int j = 0; j < 16; j++) chk("inst0_phase", ph_log[j], lit0[j]);
      // overflow on 5th gate cycle
      cyc(1, 0, 0); run(3); cyc(0, 0, 1); run(12);
      chk("ovf_err_set", int'(o0[5]), 1);
      // abort on 4th gate cycle
      cyc(1, 0, 0); run(2); cyc(0, 1, 0);
      chk("abort_clr", int'(o0[2]), 1);
      chk("abort_enb", int'(o0[0]), 0);
      run(1);
      chk("abort_idle", int'(o0[8:6]), 0);
      chk("abort_ovf_kept", int'(o0[5]), 1);
      run(3);
      // clean run clears ovf_err
      cyc(1, 0, 0); run(15);
      chk("ovf_err_clear", int'(o0[5]), 0);
      // start tied high: 16-cycle period
      r1 = -1; r2 = -1; pe = 0;
      for (int j = 0; j < 40; j++) begin
         cyc(1, 0, 0);
         if (o0[0] && !pe) begin if (r1 < 0) r1 = j; else if (r2 < 0) r2 = j; end
         pe = o0[0];
      end
      chk("enb_period", r2 - r1, 16);
      run(20);
      // async reset during LATCH
      cyc(1, 0, 0); run(9);
      chk("in_latch", int'(o0[1]), 1);
      #2 rst_n = 0;
      #1;
      chk("async_lock", int'(o0[1]), 0);
      chk("async_busy", int'(o0[3]), 0);
      chk("async_phase", int'(o0[8:6]), 0);
      model_reset();
      check_all();
      @(negedge clk);
      check_all();
      rst_n = 1;
      dn = -1;
      cyc(1, 0, 0);
      for (int j = 1; j < 16; j++) begin
         cyc(0, 0, 0);
         if (o0[4] && dn < 0) dn = j;
      end
      chk("restart_done_at", dn, 14);
`ifdef FMS_AUTO_REPEAT_EN
      rpt = 1; r1 = -1; r2 = -1; pe = 0;
      cyc(1, 0, 0);
      for (int j = 1; j < 40; j++) begin
         cyc(0, 0, 0);
         if (o0[0] && !pe) begin if (r1 < 0) r1 = j; else if (r2 < 0) r2 = j; end
         pe = o0[0];
      end
      chk("repeat_period", r2 - r1, 15);
      cyc(0, 1, 0); run(20); rpt = 0;
`endif
      // randomized traffic
      for (int j = 0; j < 1500; j++)
         cyc($urandom_range(2) == 0, $urandom_range(24) == 0, $urandom_range(7) == 0);
      $display("[TB] %0d tests run, %0d failed", cmp_n, fail_n);
      $finish;
   end
endmodule
